// File: rtl/hub75_pkg.sv
// Shared parameters, pixel types and write-FSM states for the HUB75 frame buffer.
package hub75_pkg;
  localparam int COLS      = 32;
  localparam int ROW_PAIRS = 8;
  localparam int CW        = 3;

  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(ROW_PAIRS);
  localparam int WORDS  = ROW_PAIRS * COLS;
  localparam int WORD_W = $clog2(WORDS);
  localparam int ADDR_W = WORD_W + 1;

  typedef logic [CW-1:0]   pixel_t;
  typedef logic [2*CW-1:0] pair_t;

  typedef enum logic [1:0] {IDLE, FILL, WAIT_SWAP} fb_state_t;

  function automatic logic [WORD_W-1:0] rd_word(input logic [ROW_W-1:0] row,
                                                input logic [COL_W-1:0] col);
    return WORD_W'(int'(row) * COLS + int'(col));
  endfunction
endpackage

// File: rtl/hub75_frame_buffer_if.sv
// Pixel-stream write port plus scanner read port of the HUB75 frame buffer.
interface hub75_frame_buffer_if;
  import hub75_pkg::*;

  logic             wr_valid;
  logic             wr_ready;
  logic             wr_sof;
  pixel_t           wr_rgb;
  logic             rd_en;
  logic [ROW_W-1:0] rd_row;
  logic [COL_W-1:0] rd_col;
  logic             rd_frame_end;
  pair_t            rd_data;
  logic             disp_bank;
  logic             frame_valid;
  logic             swap_pending;

  modport master (
    output wr_valid, wr_sof, wr_rgb, rd_en, rd_row, rd_col, rd_frame_end,
    input  wr_ready, rd_data, disp_bank, frame_valid, swap_pending
  );

  modport slave (
    input  wr_valid, wr_sof, wr_rgb, rd_en, rd_row, rd_col, rd_frame_end,
    output wr_ready, rd_data, disp_bank, frame_valid, swap_pending
  );
endinterface

// File: rtl/hub75_frame_buffer_bank_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module fb_bank_ram
  import hub75_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [WORD_W-1:0] waddr,
  input  pixel_t            wdata,
  input  logic              re,
  input  logic [WORD_W-1:0] raddr,
  output pixel_t            rdata
);
  pixel_t mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/hub75_frame_buffer.sv
// Double-banked 16x32 frame store feeding a HUB75 scanner; banks swap on rd_frame_end.
// Optional bring-up colour bars: define HUB75_FB_TEST_PATTERN_EN.
module hub75_frame_buffer
  import hub75_pkg::*;
(
  input logic           clk,
  input logic           areset,
  hub75_frame_buffer_if.slave bus
);
  fb_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              disp_q, fv_q;
  logic              we, ready, pending, swap;
  logic [ADDR_W-1:0] waddr;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we      = 1'b0;
    waddr   = addr_q;
    ready   = 1'b0;
    pending = 1'b0;
    swap    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.wr_valid && bus.wr_sof) begin
          we      = 1'b1;
          waddr   = '0;
          addr_d  = ADDR_W'(1);
          state_d = FILL;
        end
      end
      FILL: begin
        ready = 1'b1;
        if (bus.wr_valid) begin
          we = 1'b1;
          if (bus.wr_sof) begin
            waddr  = '0;
            addr_d = ADDR_W'(1);
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            if (addr_q == '1) state_d = WAIT_SWAP;
          end
        end
      end
      WAIT_SWAP: begin
        pending = 1'b1;
        if (bus.rd_frame_end) begin
          swap    = 1'b1;
          addr_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      disp_q  <= 1'b0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      disp_q  <= disp_q ^ swap;
      fv_q    <= fv_q | swap;
    end
  end

  assign bus.wr_ready     = ready;
  assign bus.swap_pending = pending;
  assign bus.disp_bank    = disp_q;
  assign bus.frame_valid  = fv_q;

  // Upper address half selects the bottom array; the back bank is ~disp_bank.
  logic              wr_bottom;
  logic [WORD_W-1:0] wr_word, rword;
  pixel_t            top_q [2];
  pixel_t            bot_q [2];

  assign wr_bottom = waddr[ADDR_W-1];
  assign wr_word   = waddr[WORD_W-1:0];
  assign rword     = rd_word(bus.rd_row, bus.rd_col);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fb_bank_ram u_top (
      .clk   (clk),
      .we    (we && !wr_bottom && (disp_q != 1'(b))),
      .waddr (wr_word),
      .wdata (bus.wr_rgb),
      .re    (bus.rd_en),
      .raddr (rword),
      .rdata (top_q[b])
    );
    fb_bank_ram u_bot (
      .clk   (clk),
      .we    (we && wr_bottom && (disp_q != 1'(b))),
      .waddr (wr_word),
      .wdata (bus.wr_rgb),
      .re    (bus.rd_en),
      .raddr (rword),
      .rdata (bot_q[b])
    );
  end

  // Bank select and frame-valid gate are captured with the RAM read, so the
  // output mux is equivalent to gating ahead of a single rd_data register.
  logic sel_q, gate_q;
`ifdef HUB75_FB_TEST_PATTERN_EN
  pixel_t pat_q;
`endif

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      sel_q  <= 1'b0;
      gate_q <= 1'b0;
`ifdef HUB75_FB_TEST_PATTERN_EN
      pat_q  <= '0;
`endif
    end else if (bus.rd_en) begin
      sel_q  <= disp_q;
      gate_q <= fv_q;
`ifdef HUB75_FB_TEST_PATTERN_EN
      pat_q  <= bus.rd_col[4:2];
`endif
    end
  end

`ifdef HUB75_FB_TEST_PATTERN_EN
  assign bus.rd_data = gate_q ? {top_q[sel_q], bot_q[sel_q]} : {pat_q, pat_q};
`else
  assign bus.rd_data = gate_q ? {top_q[sel_q], bot_q[sel_q]} : '0;
`endif
endmodule

// File: tb/tb_hub75_frame_buffer.sv
// Randomized scoreboard bench for hub75_frame_buffer against a frame-level reference model.
module tb_hub75_frame_buffer;
  import hub75_pkg::*;

  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  hub75_frame_buffer_if bus();

  hub75_frame_buffer dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  // Reference model: two whole frames in display (row-major) order.
  pixel_t frame_m [2][512];
  int     disp_m;
  int     wptr_m;
  bit     full_m;
  bit     fv_m;
  pair_t  exp_q [$];
  int     checks;
  int     errors;
  bit     pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pair_t expect_read(input int row, input int col);
    int a;
    logic [4:0] c;
    a = row * COLS + col;
    c = 5'(col);
    if (fv_m) return {frame_m[disp_m][a], frame_m[disp_m][256 + a]};
`ifdef HUB75_FB_TEST_PATTERN_EN
    return {c[4:2], c[4:2]};
`else
    return '0;
`endif
  endfunction

  task automatic check_status(input string tag);
    check({tag, ".wr_ready"},     32'(bus.wr_ready),     32'(!full_m));
    check({tag, ".swap_pending"}, 32'(bus.swap_pending), 32'(full_m));
    check({tag, ".disp_bank"},    32'(bus.disp_bank),    32'(disp_m));
    check({tag, ".frame_valid"},  32'(bus.frame_valid),  32'(fv_m));
  endtask

  // One clock: drive inputs, advance the model over this edge, check status after it.
  task automatic cyc(input bit v, input bit sof, input pixel_t rgb,
                     input bit re, input int row, input int col, input bit fe);
    bus.wr_valid     = v;
    bus.wr_sof       = sof;
    bus.wr_rgb       = rgb;
    bus.rd_en        = re;
    bus.rd_row       = 3'(row);
    bus.rd_col       = 5'(col);
    bus.rd_frame_end = fe;
    if (re) exp_q.push_back(expect_read(row, col));
    if (full_m) begin
      if (fe) begin
        disp_m = 1 - disp_m;
        fv_m   = 1'b1;
        full_m = 1'b0;
        wptr_m = -1;
      end
    end else if (v) begin
      if (sof) begin
        frame_m[1 - disp_m][0] = rgb;
        wptr_m = 1;
      end else if (wptr_m >= 0) begin
        frame_m[1 - disp_m][wptr_m] = rgb;
        wptr_m++;
      end
      if (wptr_m == 512) full_m = 1'b1;
    end
    @(posedge clk);
    #1;
    check_status("cyc");
    @(negedge clk);
  endtask

  // Stream pixels with random gaps, reads and stray frame ends until wptr_m hits stop.
  task automatic send_frame(input bit pat, input int stop);
    int guard;
    int addr;
    guard = 0;
    while (wptr_m != stop && !full_m && guard < 5000) begin
      addr = (wptr_m < 0) ? 0 : wptr_m;
      cyc(($urandom % 4) != 0, wptr_m < 0, pat ? 3'(addr) : 3'($urandom),
          ($urandom % 2) == 1, int'($urandom % ROW_PAIRS), int'($urandom % COLS),
          ($urandom % 8) == 0);
      guard++;
    end
    check("send_frame.bound", 32'(guard < 5000), 32'd1);
  endtask

  task automatic do_reset();
    bus.wr_valid     = 1'b0;
    bus.wr_sof       = 1'b0;
    bus.rd_en        = 1'b0;
    bus.rd_frame_end = 1'b0;
    #2 areset = 1'b0;
    #1;
    wptr_m = -1;
    full_m = 1'b0;
    disp_m = 0;
    fv_m   = 1'b0;
    check_status("reset");
    check("reset.rd_data", 32'(bus.rd_data), 32'd0);
    @(negedge clk);
    areset = 1'b1;
  endtask

  // Monitor: every registered read response is compared with the queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      pend = bus.rd_en;
      @(negedge clk);
      if (pend) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_data: response %0h with no expectation queued", bus.rd_data);
        end else begin
          check("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    areset = 1'b1;
    bus.wr_rgb = '0;
    bus.rd_row = '0;
    bus.rd_col = '0;
    for (int unsigned b = 0; b < 2; b++)
      for (int unsigned a = 0; a < 512; a++) frame_m[b][a] = '0;
    @(negedge clk);

    // Reset state and a read before any frame.
    do_reset();
    cyc(0, 0, '0, 1, 3, 7, 0);
`ifndef HUB75_FB_TEST_PATTERN_EN
    check("prefill.rd_data", 32'(bus.rd_data), 32'd0);
`endif

    // Frame of addr[2:0], then swap and read row 2 col 5.
    send_frame(1, 512);
    check("full.wr_ready", 32'(bus.wr_ready), 32'd0);
    check("full.swap_pending", 32'(bus.swap_pending), 32'd1);
    cyc(0, 0, '0, 0, 0, 0, 1);
    check("swap.disp_bank", 32'(bus.disp_bank), 32'd1);
    cyc(0, 0, '0, 1, 2, 5, 0);
    check("r2c5.rd_data", 32'(bus.rd_data), 32'o55);

    // Last pixel coincides with rd_frame_end: no swap until the next one.
    send_frame(0, 511);
    cyc(1, 0, 3'($urandom), 1, 1, 9, 1);
    check("coincident.disp_bank", 32'(bus.disp_bank), 32'd1);
    cyc(0, 0, '0, 1, 4, 4, 0);
    cyc(0, 0, '0, 1, 4, 4, 1);
    check("second_fe.disp_bank", 32'(bus.disp_bank), 32'd0);

    // 100 pixels, restart with wr_sof, full frame; sweep the first 128 words.
    send_frame(0, 100);
    cyc(1, 1, 3'($urandom), 0, 0, 0, 0);
    send_frame(0, 512);
    cyc(0, 0, '0, 0, 0, 0, 1);
    for (int a = 0; a < 128; a++) cyc(0, 0, '0, 1, a / COLS, a % COLS, 0);

    // Pixels without wr_sof in IDLE are dropped; reads on row 0 straddle the swap.
    for (int i = 0; i < 10; i++) cyc(1, 0, 3'($urandom), 1, 0, i, 0);
    send_frame(0, 512);
    for (int i = 0; i < 8; i++) cyc(0, 0, '0, 1, 0, i, i == 3);
    for (int a = 0; a < 512; a += 7) cyc(0, 0, '0, 1, (a / COLS) % ROW_PAIRS, a % COLS, 0);

    // Reset in the middle of a fill, then probe the unfilled output.
    send_frame(0, 200);
    do_reset();
    cyc(0, 0, '0, 1, 0, 20, 0);
`ifdef HUB75_FB_TEST_PATTERN_EN
    check("pattern.rd_data", 32'(bus.rd_data), 32'b101101);
`else
    check("postreset.rd_data", 32'(bus.rd_data), 32'd0);
`endif

    // Recovery: stray pixels dropped, full random frame, swap, random reads.
    for (int i = 0; i < 5; i++) cyc(1, 0, 3'($urandom), 0, 0, 0, 0);
    send_frame(0, 512);
    cyc(0, 0, '0, 1, 7, 31, 1);
    for (int i = 0; i < 200; i++)
      cyc(0, 0, '0, 1, int'($urandom % ROW_PAIRS), int'($urandom % COLS), 0);

    cyc(0, 0, '0, 0, 0, 0, 0);
    cyc(0, 0, '0, 0, 0, 0, 0);
    check("scoreboard.drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hub75_frame_buffer.md
Name: hub75_frame_buffer

Overview:
- Double-banked frame store directly upstream of the HUB75 row scanner. The scanner drives r1/g1/b1/r2/g2/b2, abc, oclk, lat and oe.
- Accepts a row-major pixel stream for a 16x32 panel, 1 bit per colour channel, into the back bank.
- Serves the scanner's (row pair, column) reads from the front bank.
- Swaps banks only at a scanner frame boundary, so a partially written frame is never displayed.

Parameters:
- COLS, 32, pixels per row (column address width = $clog2(COLS)).
- ROW_PAIRS, 8, scanned row pairs (abc width = $clog2(ROW_PAIRS)); the panel has 2*ROW_PAIRS rows.
- CW, 3, colour bits per pixel {r,g,b}.

Ports:
- clk  in  1  system clock (the lsoscillator output at top level).
- areset  in  1  asynchronous active-low reset.
- wr_valid  in  1  pixel present on wr_rgb.
- wr_ready  out  1  block can accept a pixel this cycle.
- wr_sof  in  1  qualifies the pixel as the first pixel of a frame (row 0, col 0).
- wr_rgb  in  CW  pixel {r,g,b}.
- rd_en  in  1  scanner read strobe.
- rd_row  in  $clog2(ROW_PAIRS)  row pair; equals abc.
- rd_col  in  $clog2(COLS)  column.
- rd_frame_end  in  1  one-cycle pulse from the scanner after the last row pair is latched.
- rd_data  out  2*CW  {r1,g1,b1,r2,g2,b2}; valid one cycle after rd_en.
- disp_bank  out  1  index of the front bank.
- frame_valid  out  1  a complete frame has been swapped in since reset.
- swap_pending  out  1  back bank is full and waiting for rd_frame_end.

Behaviour:
- Reset (areset low, asynchronous) forces:
  - state IDLE, write address 0;
  - wr_ready=1, rd_data=0, disp_bank=0, frame_valid=0, swap_pending=0.
- RAM contents are not reset.
- Handshake: a pixel is accepted when wr_valid & wr_ready. wr_rgb and wr_sof are sampled only on an accepting edge.
- Write address is 9 bits (0..511). For address a:
  - row = a/COLS; col = a%COLS;
  - row < ROW_PAIRS writes the top array at word row*COLS+col;
  - otherwise writes the bottom array at word (row-ROW_PAIRS)*COLS+col.
- Writes always target back bank = ~disp_bank.
- Write FSM:
  - IDLE: wr_ready=1. Accepted pixels without wr_sof are discarded. An accepted wr_sof pixel is written at address 0; address becomes 1; go to FILL.
  - FILL: wr_ready=1. Each accepted pixel is written at the current address and the address increments. An accepted wr_sof pixel restarts: written at 0, address becomes 1. Accepting address 511 goes to WAIT_SWAP.
  - WAIT_SWAP: wr_ready=0 and swap_pending=1. On rd_frame_end, disp_bank toggles, frame_valid is set, and the FSM goes to IDLE.
  - Illegal state encodings go to IDLE.
- Simultaneous events:
  - If rd_frame_end arrives on the same edge that accepts pixel 511, no swap occurs; the next rd_frame_end swaps.
  - rd_frame_end in IDLE or FILL is ignored.
  - wr_sof is not visible in WAIT_SWAP because wr_ready=0.
- Read path:
  - On rd_en, rd_data is registered next cycle as {top[disp_bank][rd_row*COLS+rd_col], bottom[disp_bank][rd_row*COLS+rd_col]}.
  - disp_bank is sampled on the rd_en edge, so reads issued on the swap edge return the old bank.
  - When rd_en is low, rd_data holds its value.
  - While frame_valid=0, rd_data is 0 (gated before the register).
- Reset asserted mid-frame discards the partial frame; the next frame must begin with wr_sof.
- Throughput: one pixel per cycle on write; one read per cycle; reads and writes are concurrent and independent.

Optional Feature:
- Macro HUB75_FB_TEST_PATTERN_EN.
- Defined: while frame_valid=0, rd_data = {rd_col[4:2], rd_col[4:2]}, giving 8 colour bars for bring-up without a host. The zero-gate is not applied.
- Undefined: while frame_valid=0, rd_data=0. No test-pattern logic is synthesised.
- All other behaviour is identical in both builds.

Decomposition:
- Package hub75_pkg holds:
  - COLS, ROW_PAIRS, CW localparams;
  - typedef pixel_t = logic [CW-1:0];
  - typedef pair_t = logic [2*CW-1:0];
  - enum fb_state_t {IDLE, FILL, WAIT_SWAP}.
- Sub-module fb_bank_ram: simple dual-port RAM, ROW_PAIRS*COLS words of CW bits, one write port, one registered read port, no reset. Instanced 4 times: top and bottom arrays, each for banks 0 and 1.

Test Plan:
- Reset, then rd_en at row 3, col 7 -> rd_data=6'b0 next cycle; disp_bank=0, frame_valid=0, wr_ready=1.
- Stream 512 pixels, first with wr_sof, value = addr[2:0] -> wr_ready=0 and swap_pending=1 after pixel 511. Pulse rd_frame_end -> disp_bank=1, frame_valid=1. Read row 2, col 5 -> {3'd5, 3'd5} (addresses 69 and 325).
- Pixel 511 accepted on the same edge as rd_frame_end -> no swap; a second rd_frame_end swaps.
- 100 pixels, then a new wr_sof pixel, then 511 more -> full frame; addresses 1..99 hold second-pass data.
- Scanner reads row 0 continuously across the swap edge -> the read on the swap edge returns the old bank; the next read returns the new bank. Pixels sent in IDLE without wr_sof are dropped.
- areset low mid-FILL at address 200 -> IDLE, wr_ready=1, swap_pending=0, disp_bank unchanged from reset value 0. With HUB75_FB_TEST_PATTERN_EN, read col 20 -> rd_data=6'b101101.
